// File: rtl/if_stage.sv
// Instruction fetch stage: single-outstanding-request fetch FSM feeding a
// 2-entry {pc+4, instruction} FIFO, with branch redirect and flush.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc_out,
  output logic        inst_valid
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  logic [1:0]  state_r;
  logic [1:0]  state_nxt_s;
  logic [31:0] pc_r;
  logic [31:0] pc_nxt_s;
  logic [31:0] addr_r;
  logic [31:0] addr_nxt_s;
  logic        req_r;
  logic [1:0]  count_r;
  logic [1:0]  count_nxt_s;
  logic        rd_ptr_r;
  logic        wr_ptr_r;
  logic [31:0] fifo_pc_r   [2];
  logic [31:0] fifo_inst_r [2];
  logic        valid_s;
  logic        redirect_s;
  logic        pop_s;
  logic        push_s;

  assign valid_s     = (count_r != 2'd0);
  assign redirect_s  = valid_s & br_taken & ~freeze;
  assign pop_s       = valid_s & ~freeze;

  assign imem_req    = req_r;
  assign imem_addr   = addr_r;
  assign inst_valid  = valid_s;
  assign instruction = fifo_inst_r[rd_ptr_r];
  assign pc_out      = fifo_pc_r[rd_ptr_r];

  // Fetch FSM: next state, next PC, next request address and push decision
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    addr_nxt_s  = addr_r;
    push_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (redirect_s) begin
          pc_nxt_s    = br_target;
          addr_nxt_s  = br_target;
          state_nxt_s = ST_WAIT;
        end else if (count_r != 2'd2) begin
          addr_nxt_s  = pc_r;
          state_nxt_s = ST_WAIT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (imem_ack) begin
          if (redirect_s) begin
            pc_nxt_s = br_target;
          end else begin
            push_s   = 1'b1;
            pc_nxt_s = addr_r + 32'd4;
          end
          state_nxt_s = ST_IDLE;
        end else if (redirect_s) begin
          // Request stays on the bus unchanged; its data will be discarded
          pc_nxt_s    = br_target;
          state_nxt_s = ST_DROP;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_DROP: begin
        if (imem_ack) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DROP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FIFO occupancy: a redirect flushes everything including a same-cycle push
  always_comb begin
    count_nxt_s = count_r;
    if (redirect_s) begin
      count_nxt_s = 2'd0;
    end else begin
      case ({push_s, pop_s})
        2'b10:   count_nxt_s = count_r + 2'd1;
        2'b01:   count_nxt_s = count_r - 2'd1;
        default: count_nxt_s = count_r;
      endcase
    end
  end

  // Fetch control state and request outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      pc_r    <= RESET_PC;
      addr_r  <= 32'd0;
      req_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      pc_r    <= pc_nxt_s;
      addr_r  <= addr_nxt_s;
      req_r   <= (state_nxt_s != ST_IDLE);
    end
  end

  // FIFO pointers, count and storage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r  <= 2'd0;
      rd_ptr_r <= 1'b0;
      wr_ptr_r <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        fifo_pc_r[i]   <= 32'd0;
        fifo_inst_r[i] <= 32'd0;
      end
    end else begin
      count_r <= count_nxt_s;
      if (redirect_s) begin
        rd_ptr_r <= 1'b0;
        wr_ptr_r <= 1'b0;
      end else begin
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + 1'b1;
        end
        if (push_s) begin
          wr_ptr_r              <= wr_ptr_r + 1'b1;
          fifo_pc_r[wr_ptr_r]   <= addr_r + 32'd4;
          fifo_inst_r[wr_ptr_r] <= imem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Randomized self-checking bench for if_stage against a queue-based
// transaction model of the fetch stage.
module tb_if_stage;

  localparam logic [31:0] TB_RESET_PC = 32'h0000_0040;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        br_taken;
  logic [31:0] br_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic        inst_valid;

  int total = 0;
  int bad   = 0;

  if_stage #(.RESET_PC(TB_RESET_PC)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .br_taken(br_taken),
    .br_target(br_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instruction(instruction),
    .pc_out(pc_out), .inst_valid(inst_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc4;
    logic [31:0] inst;
  } ent_t;

  ent_t        q[$];
  bit          m_pend;
  bit          m_drop;
  logic [31:0] m_pc;
  logic [31:0] m_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_A5A5;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pend = 1'b0;
    m_drop = 1'b0;
    m_pc   = TB_RESET_PC;
    m_addr = 32'd0;
  endtask

  // One clock edge of the reference: at most one request in flight, FIFO as a queue
  task automatic model_step();
    int   n;
    bit   valid;
    bit   redir;
    bit   pop;
    bit   push;
    ent_t e;
    n     = q.size();
    valid = (n != 0);
    redir = valid && br_taken && !freeze;
    pop   = valid && !freeze;
    push  = 1'b0;
    e.pc4 = 32'd0;
    e.inst = 32'd0;
    if (!m_pend) begin
      if (redir) begin
        m_pc = br_target; m_addr = br_target; m_pend = 1'b1; m_drop = 1'b0;
      end else if (n < 2) begin
        m_addr = m_pc; m_pend = 1'b1; m_drop = 1'b0;
      end
    end else if (imem_ack) begin
      m_pend = 1'b0;
      if (!m_drop) begin
        if (redir) m_pc = br_target;
        else begin
          push   = 1'b1;
          e.pc4  = m_addr + 32'd4;
          e.inst = mem_word(m_addr);
          m_pc   = m_addr + 32'd4;
        end
      end
    end else if (redir) begin
      m_drop = 1'b1;
      m_pc   = br_target;
    end
    if (redir) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(e);
    end
  endtask

  task automatic compare_all();
    check_eq("imem_req", {31'd0, imem_req}, {31'd0, m_pend});
    check_eq("imem_addr", imem_addr, m_addr);
    check_eq("inst_valid", {31'd0, inst_valid}, {31'd0, (q.size() != 0)});
    if (q.size() != 0) begin
      check_eq("instruction", instruction, q[0].inst);
      check_eq("pc_out", pc_out, q[0].pc4);
    end
  endtask

  task automatic drive(input bit f, input bit b, input bit a, input logic [31:0] t);
    freeze     = f;
    br_taken   = b;
    imem_ack   = a;
    br_target  = t;
    imem_rdata = mem_word(imem_addr);
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) model_step();
    @(negedge clk);
    compare_all();
    if (!rst) rst = 1'b1;
  endtask

  // Assert reset asynchronously between edges and check the immediate effect
  task automatic reset_pulse();
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_eq("rst_req", {31'd0, imem_req}, 32'd0);
    check_eq("rst_valid", {31'd0, inst_valid}, 32'd0);
    check_eq("rst_pc_out", pc_out, 32'd0);
    check_eq("rst_instr", instruction, 32'd0);
    compare_all();
  endtask

  function automatic logic [31:0] pick_target();
    case ($urandom_range(3))
      0:       return 32'h0000_0100;
      1:       return 32'hFFFF_FFF8;
      2:       return 32'hFFFF_FFFC;
      default: return $urandom() & 32'hFFFF_FFFC;
    endcase
  endfunction

  initial begin
    bit found;
    clk = 1'b0;
    rst = 1'b0;
    freeze = 1'b0; br_taken = 1'b0; br_target = 32'd0;
    imem_ack = 1'b0; imem_rdata = 32'd0;
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("reset_req", {31'd0, imem_req}, 32'd0);
    check_eq("reset_addr", imem_addr, 32'd0);
    check_eq("reset_valid", {31'd0, inst_valid}, 32'd0);
    check_eq("reset_instr", instruction, 32'd0);
    check_eq("reset_pc_out", pc_out, 32'd0);
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 32'd0);

    // Streaming with a zero-wait memory
    for (int c = 0; c < 20; c++) begin cycle(); drive(1'b0, 1'b0, 1'b1, 32'd0); end
    // Frozen downstream, including a held branch that must be ignored
    for (int c = 0; c < 12; c++) begin cycle(); drive(1'b1, c[2], 1'b1, 32'h0000_0100); end
    // Freeze drops with branch still asserted
    cycle(); drive(1'b0, 1'b1, 1'b0, 32'h0000_0100);
    // Slow memory
    for (int c = 0; c < 40; c++) begin cycle(); drive(1'b0, 1'b0, ($urandom_range(3) == 0), 32'd0); end
    // Redirect while a request is pending without ack
    for (int c = 0; c < 40; c++) begin
      cycle();
      drive(1'b0, ($urandom_range(2) == 0), ($urandom_range(3) == 0), 32'h0000_0100);
    end

    // Reset while a request is outstanding and one entry is held
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      cycle();
      if (m_pend && !m_drop && q.size() == 1) begin
        found = 1'b1;
        reset_pulse();
        drive(1'b0, 1'b0, 1'b1, 32'd0);
      end else begin
        drive(1'b1, 1'b0, ($urandom_range(1) == 0), 32'd0);
      end
    end
    check_eq("rst_in_wait_found", {31'd0, found}, 32'd1);
    for (int c = 0; c < 6; c++) begin cycle(); drive(1'b0, 1'b0, 1'b1, 32'd0); end

    // Fully random traffic with occasional async resets
    for (int c = 0; c < 1500; c++) begin
      cycle();
      if ($urandom_range(99) == 0) reset_pulse();
      drive(($urandom_range(3) == 0), ($urandom_range(4) == 0),
            ($urandom_range(1) == 0), pick_target());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
